// File: rtl/addsub_sched_pkg.sv
// Shared widths and FSM state encoding for the add/subtract scheduler.
package addsub_sched_pkg;
  localparam int OPW  = 8;
  localparam int RESW = 9;
  localparam int CNTW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/addsub_rr_pick.sv
// Combinational round-robin picker: searches upward from rr_last+1, wrapping at NREQ.
module addsub_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [IDW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_last) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one registered 8-bit add/subtract unit among NREQ requesters.
// Per-requester accept counters exist only when ADDSUB_SCHED_STATS_EN is defined.
module addsub_sched
  import addsub_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OPW*NREQ-1:0]  req_a,
  input  logic [OPW*NREQ-1:0]  req_b,
  input  logic [NREQ-1:0]      req_add,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [RESW-1:0]      rsp_result
`ifdef ADDSUB_SCHED_STATS_EN
  ,output logic [CNTW*NREQ-1:0] grant_cnt
`endif
);
  // state | meaning
  // IDLE  | arbitrate, accept winner and capture its operands
  // EXEC  | compute result into the result register
  // RESP  | hold result until the consumer takes it
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]      state;
  logic [IDW-1:0]  rr_last;
  logic [IDW-1:0]  w_q;
  logic [OPW-1:0]  a_q, b_q;
  logic            add_q;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [OPW-1:0]  sel_a, sel_b;
  logic            sel_add;
  logic            accept;

  addsub_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req     (req_valid),
    .rr_last (rr_last),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign accept    = rst_n && (state == ST_IDLE) && pick_any;
  assign req_ready = accept ? pick_gnt : '0;
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_add = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        sel_a   = req_a[i*OPW +: OPW];
        sel_b   = req_b[i*OPW +: OPW];
        sel_add = req_add[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_last    <= IDW'(NREQ - 1);
      w_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      add_q      <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            add_q   <= sel_add;
            w_q     <= pick_idx;
            rr_last <= pick_idx;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Bit 8 is carry on add and borrow on subtract.
          rsp_result <= add_q ? ({1'b0, a_q} + {1'b0, b_q})
                              : ({1'b0, a_q} - {1'b0, b_q});
          rsp_id     <= w_q;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDSUB_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pick_idx == IDW'(i))
          grant_cnt[i*CNTW +: CNTW] <= grant_cnt[i*CNTW +: CNTW] + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_addsub_sched.sv
// Directed bench for addsub_sched: vector table plus reset, round-robin, backpressure
// and (with ADDSUB_SCHED_STATS_EN) counter sequences.
module tb_addsub_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_add = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_result;
`ifdef ADDSUB_SCHED_STATS_EN
  logic [63:0] grant_cnt;
`endif

  addsub_sched #(.NREQ(4), .IDW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_add    (req_add),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef ADDSUB_SCHED_STATS_EN
    ,.grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       add;
    logic [8:0] res;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic add);
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
    req_add[idx]      = add;
  endtask

  // Returns at negedge+1 of the cycle in which a masked requester sees req_ready.
  task automatic wait_ready(input logic [3:0] mask, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((req_ready & mask) != 4'b0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_op(input vec_t v, input string tag);
    bit ok;
    rsp_ready = 1'b1;
    set_req(int'(v.idx), v.a, v.b, v.add);
    req_valid = 4'b1 << v.idx;
    wait_ready(req_valid, ok);
    chk({tag, " accept"}, 64'(ok), 64'd1);
    if (!ok) begin
      req_valid = '0;
      return;
    end
    chk({tag, " ready onehot"}, 64'(req_ready), 64'(4'b1 << v.idx));
    @(posedge clk);
    @(negedge clk);
    // Operands change after accept; the response must still use the captured ones.
    req_valid = '0;
    set_req(int'(v.idx), 8'($urandom), 8'($urandom), ~v.add);
    #1;
    chk({tag, " exec no valid"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, " rsp_id"}, 64'(rsp_id), 64'(v.idx));
    chk({tag, " rsp_result"}, 64'(rsp_result), 64'(v.res));
    chk({tag, " ready low in resp"}, 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " rsp dropped"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int gi;
    vec_t v;

    vecs[0] = '{idx: 2'd0, a: 8'd200, b: 8'd100, add: 1'b1, res: 9'd300};
    vecs[1] = '{idx: 2'd2, a: 8'd3,   b: 8'd5,   add: 1'b0, res: 9'h1FE};
    vecs[2] = '{idx: 2'd1, a: 8'd255, b: 8'd255, add: 1'b1, res: 9'h1FE};
    vecs[3] = '{idx: 2'd3, a: 8'd0,   b: 8'd0,   add: 1'b0, res: 9'h000};
    vecs[4] = '{idx: 2'd1, a: 8'd0,   b: 8'd1,   add: 1'b0, res: 9'h1FF};
    vecs[5] = '{idx: 2'd3, a: 8'd255, b: 8'd1,   add: 1'b1, res: 9'h100};
    vecs[6] = '{idx: 2'd0, a: 8'd10,  b: 8'd10,  add: 1'b0, res: 9'h000};
    vecs[7] = '{idx: 2'd2, a: 8'd128, b: 8'd127, add: 1'b0, res: 9'h001};

    // Reset state, with every requester already valid.
    for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd1, 1'b1);
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_id", 64'(rsp_id), 64'd0);
    chk("reset rsp_result", 64'(rsp_result), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all requesters continuously valid.
    for (int g = 0; g < 8; g++) begin
      wait_ready(4'hF, ok);
      chk($sformatf("rr grant %0d seen", g), 64'(ok), 64'd1);
      gi = -1;
      for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
      chk($sformatf("rr grant %0d idx", g), 64'(gi), 64'(g % 4));
      chk($sformatf("rr grant %0d onehot", g), 64'($countones(req_ready)), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end
    drain();

    for (int n = 0; n < 8; n++) do_op(vecs[n], $sformatf("vec%0d", n));
    drain();

    // Backpressure on requester 1 while others wait.
    rsp_ready = 1'b0;
    set_req(1, 8'd10, 8'd20, 1'b1);
    req_valid = 4'b0010;
    wait_ready(4'b0010, ok);
    chk("bp accept", 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (i != 1) set_req(i, 8'd50, 8'd5, 1'b0);
    req_valid = 4'b1101;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp valid %0d", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp id %0d", c), 64'(rsp_id), 64'd1);
      chk($sformatf("bp result %0d", c), 64'(rsp_result), 64'd30);
      chk($sformatf("bp ready %0d", c), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp released", 64'(rsp_valid), 64'd0);
    chk("bp next grant", 64'(req_ready), 64'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("bp next id", 64'(rsp_id), 64'd2);
    chk("bp next result", 64'(rsp_result), 64'd45);
    drain();

    // Reset during EXEC discards the op; requester 0 is favoured afterwards.
    set_req(0, 8'd7, 8'd8, 1'b1);
    req_valid = 4'b0001;
    wait_ready(4'b0001, ok);
    chk("mid accept", 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid no rsp %0d", c), 64'(rsp_valid), 64'd0);
    end
    set_req(0, 8'd1, 8'd2, 1'b1);
    set_req(1, 8'd9, 8'd4, 1'b0);
    req_valid = 4'b0011;
    wait_ready(4'b0011, ok);
    chk("post reset grant", 64'(req_ready), 64'b0001);
    drain();

`ifdef ADDSUB_SCHED_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      v = '{idx: 2'd3, a: 8'(n), b: 8'd1, add: 1'b1, res: 9'(n + 1)};
      do_op(v, $sformatf("stats%0d", n));
    end
    chk("stats cnt3", 64'(grant_cnt[63:48]), 64'd5);
    chk("stats others", 64'(grant_cnt[47:0]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
